// File: rtl/alu_shift_seq_pkg.sv
// Shared types and constants for the sequential shift/rotate unit.
// Holds the FSM encoding, the op encoding and the one-hot select decode.
package alu_shift_seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned SEL_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_SHR  = 3'd0,
    OP_SHRA = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4
  } op_e;

  // Select vector is ordered {SHR, SHRA, SHL, ROR, ROL}.
  function automatic logic sel_onehot(input logic [SEL_W-1:0] sel);
    return (sel != '0) && ((sel & SEL_W'(sel - SEL_W'(1))) == '0);
  endfunction

  function automatic op_e sel_to_op(input logic [SEL_W-1:0] sel);
    op_e op;
    case (sel)
      5'b10000: op = OP_SHR;
      5'b01000: op = OP_SHRA;
      5'b00100: op = OP_SHL;
      5'b00010: op = OP_ROR;
      default:  op = OP_ROL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_shift_seq_step1.sv
// Single-bit shift/rotate step applied once per RUN cycle.
module shift_step1
  import alu_shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  op_e               op,
  output logic [DATA_W-1:0] stepped_c
);

  always_comb begin
    stepped_c = value;
    case (op)
      OP_SHR:  stepped_c = {1'b0, value[DATA_W-1:1]};
      OP_SHRA: stepped_c = {value[DATA_W-1], value[DATA_W-1:1]};
      OP_SHL:  stepped_c = {value[DATA_W-2:0], 1'b0};
      OP_ROR:  stepped_c = {value[0], value[DATA_W-1:1]};
      OP_ROL:  stepped_c = {value[DATA_W-2:0], value[DATA_W-1]};
      default: stepped_c = value;
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Sequential shifter: one bit per cycle, n+1 cycle latency, done/err pulse,
// result register c holds the last legal result.
module alu_shift_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              SHR,
  input  logic              SHRA,
  input  logic              SHL,
  input  logic              ROR,
  input  logic              ROL,
  output logic [DATA_W-1:0] c,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import alu_shift_seq_pkg::*;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]   c_q, c_d;
  logic [AMT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [SEL_W-1:0]    sel;
  logic [DATA_W-1:0]   step_c;
  logic [AMT_W-1:0]    amt;
  logic                unused_b_hi;

  assign sel         = {SHR, SHRA, SHL, ROR, ROL};
  assign amt         = b[AMT_W-1:0];
  assign unused_b_hi = ^b[DATA_W-1:AMT_W];

  shift_step1 u_step (
    .value     (work_q),
    .op        (op_q),
    .stepped_c (step_c)
  );

  // Next-state, datapath and output decode; done/err/c are set on entry to FIN
  // so they are visible together during the FIN cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (sel_onehot(sel)) begin
            work_d = a;
            cnt_d  = amt;
            op_d   = sel_to_op(sel);
            if (amt == '0) begin
              state_d = FIN;
              c_d     = a;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        work_d = step_c;
        cnt_d  = AMT_W'(cnt_q - AMT_W'(1));
        if (cnt_q == AMT_W'(1)) begin
          state_d = FIN;
          c_d     = step_c;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_SHR;
      work_q  <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign c    = c_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed and LFSR-random checks of alu_shift_seq against hand values and a
// whole-amount shift model.
module tb_alu_shift_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        SHR, SHRA, SHL, ROR, ROL;
  logic [31:0] c;
  logic        busy, done, err;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [4:0] S_SHR  = 5'b10000;
  localparam logic [4:0] S_SHRA = 5'b01000;
  localparam logic [4:0] S_SHL  = 5'b00100;
  localparam logic [4:0] S_ROR  = 5'b00010;
  localparam logic [4:0] S_ROL  = 5'b00001;

  alu_shift_seq #(.DATA_W(32), .AMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .SHR   (SHR),
    .SHRA  (SHRA),
    .SHL   (SHL),
    .ROR   (ROR),
    .ROL   (ROL),
    .c     (c),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [31:0] x, input logic [4:0] n,
                                        input logic [4:0] sel);
    logic [31:0] r;
    case (sel)
      S_SHR:   r = x >> n;
      S_SHRA:  r = 32'($signed(x) >>> n);
      S_SHL:   r = x << n;
      S_ROR:   r = (n == 5'd0) ? x : ((x >> n) | (x << (6'd32 - 6'(n))));
      default: r = (n == 5'd0) ? x : ((x << n) | (x >> (6'd32 - 6'(n))));
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'hA300_0000) : (s >> 1);
  endfunction

  // Called at a negedge; returns at a negedge with the unit back in IDLE.
  task automatic run_op(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                        input logic [4:0] sel, input logic [31:0] exp_c, input logic exp_err,
                        input int exp_lat);
    int k;
    a = ai;
    b = bi;
    {SHR, SHRA, SHL, ROR, ROL} = sel;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ai;
    b = bi ^ 32'h0000_0015;
    {SHR, SHRA, SHL, ROR, ROL} = ~sel;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, ".lat"}, 32'(k + 1), 32'(exp_lat));
    chk({tag, ".c"}, c, exp_c);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    @(posedge clk);
    #1;
    chk({tag, ".done_off"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] ra, rb;
    logic [4:0]  rsel;
    logic [31:0] exp_r;
    int          k;
    bit          saw_done;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    {SHR, SHRA, SHL, ROR, ROL} = 5'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.c", c, 32'h0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start on the very first edge after reset release.
    run_op("shr4", 32'h8000_0001, 32'd4, S_SHR, 32'h0800_0000, 1'b0, 5);
    run_op("shra31", 32'h8000_0000, 32'd31, S_SHRA, 32'hFFFF_FFFF, 1'b0, 32);
    run_op("rol1", 32'h8000_0001, 32'd1, S_ROL, 32'h0000_0003, 1'b0, 2);
    run_op("ror37", 32'h0000_0001, 32'h25, S_ROR, 32'h0800_0000, 1'b0, 6);
    run_op("shl0", 32'h1234_5678, 32'd0, S_SHL, 32'h1234_5678, 1'b0, 1);
    run_op("illegal2", 32'hDEAD_BEEF, 32'd3, S_SHR | S_SHL, 32'h1234_5678, 1'b1, 1);
    run_op("illegal0", 32'hDEAD_BEEF, 32'd3, 5'b00000, 32'h1234_5678, 1'b1, 1);
    run_op("bhi", 32'h0000_00F0, 32'hFFFF_FFE4, S_SHR, 32'h0000_000F, 1'b0, 5);

    // Restart held high from RUN through FIN must be dropped, not queued.
    a = 32'h0000_0001;
    b = 32'd3;
    {SHR, SHRA, SHL, ROR, ROL} = S_SHL;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 32'hFFFF_FFFF;
    b = 32'd1;
    {SHR, SHRA, SHL, ROR, ROL} = S_SHR;
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("busyrs.lat", 32'(k + 1), 32'd4);
    chk("busyrs.c", c, 32'h0000_0008);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("busyrs.idle", 32'(busy), 32'd0);
    chk("busyrs.c_hold", c, 32'h0000_0008);
    @(negedge clk);

    // Reset in the middle of RUN abandons the operation silently.
    a = 32'h8000_0000;
    b = 32'd31;
    {SHR, SHRA, SHL, ROR, ROL} = S_SHRA;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.c", c, 32'h0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("midrst.no_done", 32'(saw_done), 32'd0);
    chk("midrst.c_after", c, 32'h0);
    @(negedge clk);

    // LFSR-driven random requests against the whole-amount model.
    s = 32'hACE1_2468;
    for (int i = 0; i < 1000; i++) begin
      s = lfsr_next(s);
      ra = s;
      s = lfsr_next(s);
      rb = s;
      s = lfsr_next(s);
      rsel = 5'b10000 >> (s % 5);
      exp_r = model(ra, rb[4:0], rsel);
      run_op($sformatf("rnd%0d", i), ra, rb, rsel, exp_r, 1'b0, int'(rb[4:0]) + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_shift_seq.md
ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: operand/result width; only 32 is supported.
REQ-002 The block SHALL have parameter AMT_W, default 5: shift-amount width, equal to log2(DATA_W).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-006 The block SHALL have port a, input, 32 bits: operand to shift.
REQ-007 The block SHALL have port b, input, 32 bits: shift amount; only b[4:0] is used.
REQ-008 The block SHALL have ports SHR, SHRA, SHL, ROR and ROL, each input, 1 bit: one-hot op select, sampled with start.
REQ-009 The block SHALL have port c, output, 32 bits: result register.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse, coincident with done, flagging an illegal op select.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and FIN, reset state IDLE.
REQ-014 In IDLE with start=1 and exactly one op bit high, the block SHALL latch a into the working register, b[4:0] into the counter, and the op; go to RUN if b[4:0]!=0, else FIN.
REQ-015 In IDLE with start=1 and zero or more than one op bit high, the block SHALL go to FIN with err flagged; c is unchanged.
REQ-016 Each RUN cycle SHALL apply exactly one 1-bit step and decrement the counter.
- SHR: zero fill at the MSB.
- SHRA: MSB replicated.
- SHL: zero fill at the LSB.
- ROR: bit0 moves to bit31.
- ROL: bit31 moves to bit0.
REQ-017 The block SHALL leave RUN for FIN in the cycle after the step that brings the counter to 0.
REQ-018 In FIN the block SHALL drive done=1 (and err if flagged), load c from the working register (legal op only), and return to IDLE next cycle.
REQ-019 Latency SHALL be n+1 cycles from the start-sampling edge to the edge at which done is high, with n=b[4:0]; minimum 1, maximum 32.
REQ-020 busy SHALL be 1 in RUN and FIN, and 0 in IDLE.
REQ-021 start while busy SHALL be ignored (not queued); a, b and op changes during RUN SHALL have no effect.
REQ-022 A start asserted in the same cycle done is high SHALL be ignored; a new request is accepted only in IDLE.
REQ-023 c SHALL hold its last legal result until the next legal completion.
REQ-024 b[31:5] SHALL be ignored; a shift amount of 32 is impossible.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force state IDLE, c=0, busy=0, done=0, err=0, and clear the counter and working register.
REQ-026 Reset mid-operation SHALL abandon the operation with no done pulse.
REQ-027 After deassertion, the first accepted start SHALL be on the first rising edge with rst_n=1.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, an op enum {OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL} and DATA_W/AMT_W constants.
REQ-029 The 1-bit step SHALL be one combinational sub-module, shift_step1 (inputs: value, op; output: stepped value); the FSM, counter and registers live in alu_shift_seq.

Verification
REQ-030 Sequential SHR: a=0x80000001, b=4, SHR -> done 5 cycles after start, c=0x08000000, err=0.
REQ-031 Sequential SHRA: a=0x80000000, b=31, SHRA -> done after 32 cycles, c=0xFFFFFFFF.
REQ-032 Rotates: ROL a=0x80000001, b=1 -> c=0x00000003; ROR a=0x00000001, b=0x25 (low bits 5) -> c=0x08000000.
REQ-033 Zero amount and illegal op: SHL a=0x12345678, b=0 -> done next cycle, c=0x12345678; then SHR+SHL both high -> done with err=1, c still 0x12345678.
REQ-034 Busy and reset: restart while busy ignored (c matches the first request only); rst_n=0 mid-RUN -> c=0, busy=0, no done pulse.
REQ-035 Random: 1000 requests with LFSR-driven a, b and op -> c equals the reference model for every op, including arithmetic and rotate.
